// File: rtl/trp_sequencer_8.sv
// Command sequencer for an external trp unit: streams elements in, collects the
// expected number of results into a 2-entry FWFT FIFO and signals completion.
module trp_sequencer_8 #(
   parameter int WIDTH   = 8,
   parameter int MAXLEN  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_mode,
   input  logic [3:0]       cmd_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             trp_en,
   output logic [WIDTH-1:0] trp_a,
   output logic [1:0]       trp_mode,
   output logic             trp_read,
   input  logic             trp_busy,
   input  logic             trp_valid,
   input  logic [WIDTH-1:0] trp_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_last,
   output logic             done,
   output logic             err
);
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [3:0]    MAX_LEN  = 4'(MAXLEN);

   typedef enum logic [1:0] {IDLE, FEED, COLLECT, FINISH} state_t;

   state_t                   state, state_nx;
   logic                     boot_q;
   logic [1:0]               mode_q;
   logic [3:0]               len_q, in_cnt, res_cnt, exp_cnt;
   logic [TW-1:0]            tmo_cnt;
   logic                     err_q;
   logic                     trp_en_q;
   logic [WIDTH-1:0]         trp_a_q;
   logic [1:0][WIDTH-1:0]    fifo_data;
   logic [1:0]               fifo_last;
   logic                     wr_ptr, rd_ptr;
   logic [1:0]               fifo_cnt;
   logic                     fifo_empty, fifo_full;
   logic                     len_ok, cmd_fire, in_fire, push, pop, push_last;

   assign fifo_empty = (fifo_cnt == 2'd0);
   assign fifo_full  = (fifo_cnt == 2'd2);
   assign len_ok     = (cmd_len != 4'd0) && (cmd_len <= MAX_LEN);
   assign exp_cnt    = (mode_q == 2'b11) ? len_q : 4'd1;
   assign push_last  = (res_cnt == exp_cnt - 4'd1);
   assign in_fire    = in_valid && in_ready;
   assign res_valid  = !fifo_empty && !reset;
   assign pop        = res_valid && res_ready;

   // Outputs are forced to their reset values while reset is held, not just after it.
   assign trp_en   = trp_en_q && !reset;
   assign trp_a    = reset ? '0 : trp_a_q;
   assign trp_mode = reset ? 2'b00 : mode_q;
   assign res_data = res_valid ? fifo_data[rd_ptr] : '0;
   assign res_last = res_valid && fifo_last[rd_ptr];

   always_comb begin
      state_nx  = state;
      cmd_ready = 1'b0;
      cmd_fire  = 1'b0;
      in_ready  = 1'b0;
      trp_read  = 1'b0;
      push      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               cmd_ready = !boot_q && !trp_busy && fifo_empty;
               cmd_fire  = cmd_valid && cmd_ready;
               if (cmd_fire) state_nx = len_ok ? FEED : FINISH;
            end
            FEED: begin
               in_ready = 1'b1;
               if (in_valid && (in_cnt == len_q - 4'd1)) state_nx = COLLECT;
            end
            COLLECT: begin
               if (trp_valid && !fifo_full) begin
                  push     = 1'b1;
                  trp_read = 1'b1;
                  if (push_last) state_nx = FINISH;
               end else if (tmo_cnt == TMO_LAST) begin
                  state_nx = FINISH;
               end
            end
            FINISH: begin
               if (fifo_empty) begin
                  done     = 1'b1;
                  err      = err_q;
                  state_nx = IDLE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         boot_q    <= 1'b1;
         mode_q    <= 2'b00;
         len_q     <= 4'd0;
         in_cnt    <= 4'd0;
         res_cnt   <= 4'd0;
         tmo_cnt   <= '0;
         err_q     <= 1'b0;
         trp_en_q  <= 1'b0;
         trp_a_q   <= '0;
         fifo_data <= '0;
         fifo_last <= 2'b00;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         fifo_cnt  <= 2'd0;
      end else begin
         state    <= state_nx;
         boot_q   <= 1'b0;
         trp_en_q <= in_fire;
         if (in_fire) begin
            trp_a_q <= in_data;
            in_cnt  <= in_cnt + 4'd1;
         end
         if (cmd_fire) begin
            mode_q  <= cmd_mode;
            len_q   <= cmd_len;
            in_cnt  <= 4'd0;
            res_cnt <= 4'd0;
            tmo_cnt <= '0;
            err_q   <= !len_ok;
         end
         if (state == COLLECT) begin
            if (push) begin
               res_cnt <= res_cnt + 4'd1;
               tmo_cnt <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (state_nx == FINISH) err_q <= 1'b1;
            end
         end
         if (push) begin
            fifo_data[wr_ptr] <= trp_out;
            fifo_last[wr_ptr] <= push_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: tb/tb_trp_sequencer_8.sv
// Randomized bench for trp_sequencer_8: the bench plays the trp unit and compares
// every stream against results computed directly from the command and its elements.
module tb_trp_sequencer_8;
   localparam int WIDTH = 8, MAXLEN = 8, TIMEOUT = 255;

   logic             clk = 1'b0, reset;
   logic             cmd_valid, cmd_ready;
   logic [1:0]       cmd_mode;
   logic [3:0]       cmd_len;
   logic             in_valid, in_ready;
   logic [WIDTH-1:0] in_data;
   logic             trp_en;
   logic [WIDTH-1:0] trp_a;
   logic [1:0]       trp_mode;
   logic             trp_read, trp_busy, trp_valid;
   logic [WIDTH-1:0] trp_out;
   logic             res_valid, res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_last, done, err;

   trp_sequencer_8 #(.WIDTH(WIDTH), .MAXLEN(MAXLEN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .trp_en(trp_en), .trp_a(trp_a), .trp_mode(trp_mode), .trp_read(trp_read),
      .trp_busy(trp_busy), .trp_valid(trp_valid), .trp_out(trp_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Behaviour of the trp unit as seen by the bench: sum / max / xor reductions, and
   // a transpose that returns each element inverted, in order.
   function automatic logic [7:0] result_at(input logic [1:0] m, input logic [7:0] a[8],
                                            input int n, input int i);
      logic [7:0] acc;
      acc = (m == 2'd1) ? 8'd0 : 8'd0;
      if (m == 2'd3) return ~a[i];
      for (int k = 0; k < n; k++) begin
         case (m)
            2'd0: acc = acc + a[k];
            2'd1: acc = (a[k] > acc) ? a[k] : acc;
            default: acc = acc ^ a[k];
         endcase
      end
      return acc;
   endfunction

   function automatic logic [31:0] outs();
      return 32'({cmd_ready, in_ready, trp_en, trp_a, trp_mode, trp_read,
                  res_valid, res_data, res_last, done, err});
   endfunction

   task automatic idle_inputs();
      cmd_valid = 0; cmd_mode = 0; cmd_len = 0; in_valid = 0; in_data = 0;
      trp_busy = 0; trp_valid = 0; trp_out = 0; res_ready = 0;
   endtask

   task automatic do_reset();
      reset = 1; cmd_valid = 1; cmd_len = 4'd4; in_valid = 1; res_ready = 1;
      repeat (2) @(negedge clk);
      #1 chk("rst_outs", outs(), 0);
      reset = 0;
      #1 chk("rst_first_cycle", outs(), 0);
      idle_inputs();
   endtask

   task automatic run_cmd(input logic [1:0] m, input int n, input bit no_trp,
                          input bit bp, input int base);
      logic [7:0] ea[8], fa[8];
      logic [7:0] exp_res[$], tq[$];
      bit   legal, acc, hs_prev, fin;
      int   exp_n, ni, nf, nr, nreads, delay, cyc, acc_cyc, last_hs, bp_cnt;
      legal = (n >= 1) && (n <= MAXLEN);
      for (int i = 0; i < 8; i++) begin
         ea[i] = (base < 0) ? 8'($urandom) : 8'(base + i);
         fa[i] = 8'd0;
      end
      exp_n = (!legal || no_trp) ? 0 : ((m == 2'd3) ? n : 1);
      for (int i = 0; i < exp_n; i++) exp_res.push_back(result_at(m, ea, n, i));
      acc = 0; hs_prev = 0; fin = 0;
      ni = 0; nf = 0; nr = 0; nreads = 0; delay = 0; acc_cyc = 0; last_hs = 0; bp_cnt = 0;
      for (cyc = 0; cyc < 1000 && !fin; cyc++) begin
         @(negedge clk);
         cmd_valid = !acc;
         cmd_mode  = m;
         cmd_len   = 4'(n);
         trp_busy  = !acc && ($urandom_range(0, 3) == 0);
         in_valid  = acc && (ni < n) && ($urandom_range(0, 9) < 7);
         in_data   = ea[(ni < 8) ? ni : 7];
         res_ready = (bp && bp_cnt < 10) ? 1'b0 : ($urandom_range(0, 9) < 7);
         trp_valid = !no_trp && (tq.size() > 0) && (delay == 0);
         trp_out   = (tq.size() > 0) ? tq[0] : 8'd0;
         #1;
         chk("cmd_ready", cmd_ready, !acc && !trp_busy);
         chk("in_ready", in_ready, acc && legal && (ni < n));
         chk("trp_en_lat", trp_en, hs_prev);
         if (acc && !done) chk("trp_mode", trp_mode, m);
         if (!done) chk("err_no_done", err, 0);
         if (trp_en) begin
            chk("trp_a", trp_a, ea[nf]);
            fa[nf] = trp_a;
            nf++;
            if (nf == n)
               for (int i = 0; i < ((m == 2'd3) ? n : 1); i++) tq.push_back(result_at(m, fa, n, i));
         end
         hs_prev = in_valid && in_ready;
         if (hs_prev) begin
            ni++;
            if (ni == n) last_hs = cyc;
         end
         if (trp_read) begin
            chk("read_has_valid", trp_valid, 1);
            if (tq.size() > 0) void'(tq.pop_front());
            nreads++;
            delay = $urandom_range(0, 3);
         end else if (tq.size() > 0 && delay > 0) begin
            delay--;
         end
         if (res_valid && res_ready) begin
            chk("res_data", res_data, (nr < exp_res.size()) ? exp_res[nr] : 8'hxx);
            chk("res_last", res_last, nr == exp_n - 1);
            nr++;
         end
         if (bp && nreads >= 2 && bp_cnt < 10) begin
            bp_cnt++;
            if (bp_cnt == 10) begin
               chk("bp_reads", nreads, 2);
               chk("bp_pending", {trp_valid, trp_read}, 2'b10);
            end
         end
         if (done) begin
            fin = 1;
            chk("done_err", err, !legal || no_trp);
            chk("done_results", nr, exp_n);
            chk("done_reads", nreads, exp_n);
            chk("done_fed", nf, legal ? n : 0);
            if (!legal) chk("illegal_lat", cyc - acc_cyc, 1);
            if (legal && no_trp) chk("tmo_lat", cyc - last_hs, TIMEOUT + 1);
         end
         if (cmd_valid && cmd_ready) begin
            acc = 1;
            acc_cyc = cyc;
         end
      end
      if (!fin) chk("cycle_budget", 0, 1);
      idle_inputs();
   endtask

   task automatic reset_mid_feed();
      int k;
      bit got;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         cmd_valid = 1; cmd_mode = 2'd0; cmd_len = 4'd4;
         #1 got = cmd_ready;
      end
      chk("mid_cmd_accept", got, 1);
      k = 0;
      for (int i = 0; i < 20 && k < 2; i++) begin
         @(negedge clk);
         cmd_valid = 0; in_valid = 1; in_data = 8'(k + 1);
         #1 if (in_ready) k++;
      end
      chk("mid_fed", k, 2);
      @(negedge clk);
      in_valid = 0;
      do_reset();
   endtask

   initial begin
      idle_inputs();
      do_reset();
      run_cmd(2'd0, 4, 0, 0, 1);   // 1+2+3+4 = 10
      run_cmd(2'd3, 8, 0, 0, 0);   // transpose 0..7
      run_cmd(2'd3, 4, 0, 1, -1);  // result backpressure
      run_cmd(2'd0, 0, 0, 0, -1);  // illegal lengths
      run_cmd(2'd2, 9, 0, 0, -1);
      run_cmd(2'd0, 2, 1, 0, -1);  // trp unit never answers
      reset_mid_feed();
      run_cmd(2'd1, 3, 0, 0, -1);
      for (int t = 0; t < 40; t++) begin
         int n;
         n = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15))
                                         : $urandom_range(1, MAXLEN);
         run_cmd(2'($urandom_range(0, 3)), n, 0, 0, -1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/trp_sequencer_8.md
TRP_SEQUENCER_8 -- requirements
Module: trp_sequencer_8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, element/result data width.
REQ-002 SHALL have parameter MAXLEN, default 8, maximum elements per command.
REQ-003 SHALL have parameter TIMEOUT, default 255, idle cycles tolerated while awaiting a trp-unit result.
REQ-004 SHALL have ports, one per line:
 clk  in  1  sole clock, all logic on rising edge
 reset  in  1  synchronous, active-high reset
 cmd_valid  in  1  command offered
 cmd_ready  out  1  command accepted when both high
 cmd_mode  in  2  00/01/10 reduction type, 11 transpose
 cmd_len  in  4  element count, legal 1..MAXLEN
 in_valid  in  1  element offered
 in_ready  out  1  element accepted when both high
 in_data  in  WIDTH  element value
 trp_en  out  1  element strobe to trp unit
 trp_a  out  WIDTH  element to trp unit
 trp_mode  out  2  latched command mode
 trp_read  out  1  one-cycle result-consume strobe to trp unit
 trp_busy  in  1  trp unit busy
 trp_valid  in  1  trp unit result valid
 trp_out  in  WIDTH  trp unit result
 res_valid  out  1  result available
 res_ready  in  1  result consumed when both high
 res_data  out  WIDTH  result value
 res_last  out  1  final result of current command
 done  out  1  one-cycle pulse at command completion
 err  out  1  qualifies done: illegal length or timeout

Function
REQ-005 SHALL implement FSM states IDLE, FEED, COLLECT, FINISH.
REQ-006 IDLE: cmd_ready=1 only when trp_busy=0 and result FIFO empty; on handshake latch mode and len, clear counters, go FEED.
REQ-007 cmd_len=0 or >MAXLEN SHALL skip FEED/COLLECT: go FINISH with err=1, no trp_en, no results.
REQ-008 FEED: in_ready=1; each in handshake SHALL produce trp_en=1 and trp_a=in_data on the next cycle (registered, latency 1); trp_en=0 otherwise.
REQ-009 After the len-th element handshake, in_ready SHALL drop the following cycle and FSM SHALL go COLLECT.
REQ-010 Expected result count SHALL be 1 when mode!=11 and len when mode=11.
REQ-011 COLLECT: when trp_valid=1 and FIFO not full, SHALL push trp_out into FIFO and assert trp_read for exactly that cycle; trp_read=0 otherwise.
REQ-012 res_last SHALL be set on the FIFO entry holding the final expected result.
REQ-013 When final result pushed, FSM SHALL go FINISH; FINISH SHALL wait until FIFO empty, then pulse done for one cycle (err=0) and return IDLE.
REQ-014 COLLECT SHALL count consecutive cycles without a push; reaching TIMEOUT SHALL go FINISH with err=1, discarding no already-queued results.
REQ-015 Result FIFO SHALL be 2 entries, first-word-fall-through; res_valid=!empty; simultaneous push and pop when full SHALL be permitted only if pop occurs (full blocks push that cycle).
REQ-016 err SHALL be held with done for the same single cycle; err=0 whenever done=0.
REQ-017 trp_mode SHALL equal latched mode from command accept until return to IDLE.
REQ-018 in_valid while in IDLE, COLLECT or FINISH SHALL be ignored (in_ready=0).

Reset
REQ-019 reset SHALL force state IDLE, clear counters, FIFO, latched mode/len.
REQ-020 During reset and first cycle after: cmd_ready=0, in_ready=0, trp_en=0, trp_a=0, trp_mode=00, trp_read=0, res_valid=0, res_data=0, res_last=0, done=0, err=0.
REQ-021 reset asserted mid-command SHALL abort immediately with no done pulse.

Verification
REQ-022 Reduction: cmd mode=00 len=4, elements 1,2,3,4; model returns 10 -> four trp_en pulses one cycle after each handshake, one trp_read, res_data=10 res_last=1, done=1 err=0.
REQ-023 Transpose: mode=11 len=8, elements 0..7, model returns 8 results -> 8 trp_read pulses, last result res_last=1, done after FIFO drains.
REQ-024 Backpressure: transpose len=4 with res_ready=0 for 10 cycles -> exactly 2 trp_read, trp_valid left pending, no loss after res_ready=1.
REQ-025 Illegal length: cmd_len=0 and cmd_len=9 -> no trp_en, done=1 err=1 within 2 cycles.
REQ-026 Timeout: reduction len=2, model never asserts trp_valid -> done=1 err=1 exactly TIMEOUT cycles after COLLECT entry.
REQ-027 Reset mid-FEED after 2 of 4 elements -> all outputs at reset values, next command accepted normally.
